spi_command_queue: RTL

- Sits between the spi receiver and game_executioner; replaces the two-synchronizer stall/invalidate chain.
- Captures each validated SPI byte exactly once, then drives the spi clear input to retire the byte.
- Decodes the byte into move, move-valid and piece fields and buffers it in a small FIFO.
- game_executioner pops one command per game step, so bursts of button presses are not lost between game ticks.

---
 rtl/tetris_pkg.sv | 41 ++++
 rtl/spi_command_queue_if.sv | 20 ++
 rtl/spi_command_queue_cmd_fifo.sv | 53 +++++
 rtl/spi_command_queue.sv | 87 ++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared game types plus the SPI command byte layout and decode helpers.
// Pure declarations and combinational functions; no state.
// No flow control here; consumers apply their own handshake.
package tetris_pkg;

  typedef enum logic [1:0] {
    MOVE_LEFT   = 2'd0,
    MOVE_RIGHT  = 2'd1,
    MOVE_ROTATE = 2'd2,
    MOVE_DROP   = 2'd3
  } command_t;

  // Bit positions inside a received SPI command byte
  localparam int CMD_MOVE_LSB   = 0;
  localparam int CMD_PIECE_LSB  = 2;
  localparam int CMD_MVALID_BIT = 5;
  localparam int CMD_RSVD_MSB   = 7;

  typedef struct packed {
    command_t   move;
    logic       move_valid;
    logic [2:0] piece;
  } spi_cmd_t;

  // Split a byte into its fields; piece code 7 does not exist and folds to 0
  function automatic spi_cmd_t decode_spi_cmd(input logic [7:0] b);
    spi_cmd_t   c;
    logic [2:0] p;
    p            = b[CMD_PIECE_LSB +: 3];
    c.move       = command_t'(b[CMD_MOVE_LSB +: 2]);
    c.move_valid = b[CMD_MVALID_BIT];
    c.piece      = (p == 3'd7) ? 3'd0 : p;
    return c;
  endfunction

  // Reserved top bits must be zero for a byte to be trusted
  function automatic logic is_malformed(input logic [7:0] b);
    return b[CMD_RSVD_MSB -: 2] != 2'b00;
  endfunction

endpackage

// File: rtl/spi_command_queue_if.sv
// Command bus from the queue head to the game executioner.
// Head fields are combinational from registered FIFO state.
// Consumer pulls with cmd_pop while cmd_valid is high.
interface spi_command_queue_if;
  logic                cmd_pop;
  logic                cmd_valid;
  tetris_pkg::command_t cmd_move;
  logic                cmd_move_valid;
  logic [2:0]          cmd_piece;

  modport master (
    input  cmd_pop,
    output cmd_valid, cmd_move, cmd_move_valid, cmd_piece
  );

  modport slave (
    output cmd_pop,
    input  cmd_valid, cmd_move, cmd_move_valid, cmd_piece
  );
endinterface

// File: rtl/spi_command_queue_cmd_fifo.sv
// Generic first-word-fall-through FIFO with a separate occupancy counter.
// Pushed entry is visible at the head the cycle after the push edge.
// A push while full is accepted only if a pop retires the head at the same edge.
module cmd_fifo import tetris_pkg::*; #(
  parameter int  DEPTH = 4,
  parameter type T     = spi_cmd_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  T                       push_dat,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] occupancy,
  output T                       head_dat
);
  localparam int AW = $clog2(DEPTH);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_eff;
  logic          push_eff;

  assign empty    = (occupancy == '0);
  assign full     = (occupancy == (AW+1)'(DEPTH));
  assign pop_eff  = pop && !empty;
  assign push_eff = push && (!full || pop_eff);
  assign head_dat = empty ? T'('0) : mem[rd_ptr];

  // Storage array; contents are meaningless while the matching slot is unoccupied
  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + 1'b1;
      if (pop_eff)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_eff, pop_eff})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end
endmodule

// File: rtl/spi_command_queue.sv
// Captures each SPI byte once, retires it via spi_clear, queues decoded commands.
// Capture edge N -> cmd_valid in cycle N+1 when empty; spi_clear from cycle N+1.
// No backpressure to SPI: full drops well-formed bytes (counted), malformed rejected.
module spi_command_queue import tetris_pkg::*; #(
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              spi_data,
  input  logic                    spi_data_valid,
  output logic                    spi_clear,
  spi_command_queue_if.master     cmd,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic [CNT_WIDTH-1:0]    drop_count,
  output logic [CNT_WIDTH-1:0]    reject_count
);
  typedef enum logic {IDLE, CLEAR_WAIT} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t   state;
  logic     full;
  logic     empty;
  logic     capture;
  logic     malformed;
  logic     accept;
  logic     push;
  spi_cmd_t head;

  assign capture   = (state == IDLE) && spi_data_valid;
  assign malformed = is_malformed(spi_data);
  // Post-pop room: a same-cycle pop frees the slot this byte needs
  assign accept    = !full || (cmd.cmd_pop && !empty);
  assign push      = capture && !malformed && accept;

  cmd_fifo #(.DEPTH(DEPTH), .T(spi_cmd_t)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_dat  (decode_spi_cmd(spi_data)),
    .pop       (cmd.cmd_pop),
    .full      (full),
    .empty     (empty),
    .occupancy (occupancy),
    .head_dat  (head)
  );

  assign cmd.cmd_valid      = !empty;
  assign cmd.cmd_move       = head.move;
  assign cmd.cmd_move_valid = head.move_valid;
  assign cmd.cmd_piece      = head.piece;

  // Capture FSM: classify once in IDLE, then hold clear until spi drops valid
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      spi_clear    <= 1'b0;
      drop_count   <= '0;
      reject_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (spi_data_valid) begin
            if (malformed) begin
              if (reject_count != CNT_MAX) reject_count <= reject_count + 1'b1;
            end else if (!accept) begin
              if (drop_count != CNT_MAX) drop_count <= drop_count + 1'b1;
            end
            state     <= CLEAR_WAIT;
            spi_clear <= 1'b1;
          end
        end
        CLEAR_WAIT: begin
          if (!spi_data_valid) begin
            state     <= IDLE;
            spi_clear <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          spi_clear <= 1'b0;
        end
      endcase
    end
  end
endmodule
